// File: rtl/layer_arbiter_2to1.sv
// Two-requester, vector-granular round-robin front end for one shared layer engine.
// Define LAYER_ARB_PERF_EN to add saturating per-requester completed-vector counters.
module layer_arbiter_2to1 #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0_valid,
  output logic         s0_ready,
  input  logic [T-1:0] s0_data,
  input  logic         s1_valid,
  output logic         s1_ready,
  input  logic [T-1:0] s1_data,
  output logic         m0_valid,
  input  logic         m0_ready,
  output logic [T-1:0] m0_data,
  output logic         m1_valid,
  input  logic         m1_ready,
  output logic [T-1:0] m1_data,
  output logic         e_s_valid,
  input  logic         e_s_ready,
  output logic [T-1:0] e_data_in,
  input  logic         e_m_valid,
  output logic         e_m_ready,
  input  logic [T-1:0] e_data_out,
`ifdef LAYER_ARB_PERF_EN
  output logic [15:0]  done_cnt0,
  output logic [15:0]  done_cnt1,
`endif
  output logic         busy,
  output logic         owner
);

  // state | meaning
  // IDLE  | no grant held; pending requests are arbitrated here
  // FEED  | owner streams its N input words into the engine
  // DRAIN | owner receives the M result words from the engine
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  localparam int IW = $clog2(N + 1);
  localparam int OW = $clog2(M + 1);
  localparam logic [IW-1:0] IN_LAST  = IW'(N - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(M - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic          winner;
  logic          final_hs;

  // On a tie the requester not served last wins.
  assign winner = (s0_valid && s1_valid) ? ~last_grant_q : s1_valid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    final_hs     = 1'b0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    m0_valid     = 1'b0;
    m1_valid     = 1'b0;
    m0_data      = '0;
    m1_data      = '0;
    e_s_valid    = 1'b0;
    e_data_in    = '0;
    e_m_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          state_d  = FEED;
          owner_d  = winner;
          in_cnt_d = '0;
        end
      end
      FEED: begin
        e_s_valid = owner_q ? s1_valid : s0_valid;
        e_data_in = owner_q ? s1_data : s0_data;
        s0_ready  = !owner_q && e_s_ready;
        s1_ready  = owner_q && e_s_ready;
        if (e_s_valid && e_s_ready) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_LAST) begin
            state_d   = DRAIN;
            out_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        m0_valid  = !owner_q && e_m_valid;
        m1_valid  = owner_q && e_m_valid;
        m0_data   = owner_q ? '0 : e_data_out;
        m1_data   = owner_q ? e_data_out : '0;
        e_m_ready = owner_q ? m1_ready : m0_ready;
        if (e_m_valid && e_m_ready) begin
          out_cnt_d = out_cnt_q + 1'b1;
          final_hs  = (out_cnt_q == OUT_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
    if (final_hs) begin
      state_d      = IDLE;
      last_grant_d = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

`ifdef LAYER_ARB_PERF_EN
  logic [15:0] done_cnt0_q, done_cnt0_d;
  logic [15:0] done_cnt1_q, done_cnt1_d;

  always_comb begin
    done_cnt0_d = done_cnt0_q;
    done_cnt1_d = done_cnt1_q;
    if (final_hs && !owner_q && done_cnt0_q != 16'hFFFF) done_cnt0_d = done_cnt0_q + 16'd1;
    if (final_hs && owner_q && done_cnt1_q != 16'hFFFF) done_cnt1_d = done_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_cnt0_q <= '0;
      done_cnt1_q <= '0;
    end else begin
      done_cnt0_q <= done_cnt0_d;
      done_cnt1_q <= done_cnt1_d;
    end
  end

  assign done_cnt0 = done_cnt0_q;
  assign done_cnt1 = done_cnt1_q;
`endif

endmodule

// File: doc/layer_arbiter_2to1.md
# layer_arbiter_2to1

Round-robin arbiter that shares one fully-connected layer engine (N-word input vector in, M-word output vector out, valid/ready on both sides) between two independent requester streams. Grants are vector-granular: the winner streams its whole N-word input vector, then receives all M output words, before the other requester is considered. The block sits between two upstream producers/downstream consumers and a single `layer_*` instance, so one ROM-weighted engine serves two channels.

## Interface
- `M`, 8, output words per vector (engine rows)
- `N`, 8, input words per vector (engine columns)
- `T`, 16, data word width in bits
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high; also drives the engine's reset
- `s0_valid`/`s1_valid`  in  1  requester input word valid
- `s0_ready`/`s1_ready`  out  1  requester input word accepted
- `s0_data`/`s1_data`  in  T  requester input word
- `m0_valid`/`m1_valid`  out  1  result word valid to requester
- `m0_ready`/`m1_ready`  in  1  requester consumer ready
- `m0_data`/`m1_data`  out  T  result word to requester
- `e_s_valid`  out  1  engine input valid
- `e_s_ready`  in  1  engine input ready
- `e_data_in`  out  T  engine input word
- `e_m_valid`  in  1  engine output valid
- `e_m_ready`  out  1  engine output ready
- `e_data_out`  in  T  engine output word
- `busy`  out  1  state != IDLE
- `owner`  out  1  currently granted requester (valid when busy)

## Operation
- States: IDLE, FEED, DRAIN. Registers: `state`, `owner`, `last_grant`, `in_cnt` ($clog2(N+1) bits), `out_cnt` ($clog2(M+1) bits).
- IDLE: all `s*_ready`, `m*_valid`, `e_s_valid`, `e_m_ready` = 0. If any `s*_valid`: next state FEED, `owner` <= winner, `in_cnt` <= 0.
- Winner: only one requesting -> that one; both -> the one != `last_grant`.
- FEED: `e_s_valid` = `s[owner]_valid`, `s[owner]_ready` = `e_s_ready`, `e_data_in` = `s[owner]_data`; non-owner `s_ready` = 0. Each handshake (`e_s_valid && e_s_ready`) increments `in_cnt`; handshake with `in_cnt == N-1` -> DRAIN, `out_cnt` <= 0. `e_m_ready` = 0.
- DRAIN: `m[owner]_valid` = `e_m_valid`, `e_m_ready` = `m[owner]_ready`, `m[owner]_data` = `e_data_out`; non-owner `m_valid` = 0. Each handshake increments `out_cnt`; handshake with `out_cnt == M-1` -> IDLE, `last_grant` <= `owner`. All `s*_ready` = 0.
- Non-owner `m_data` = 0; `e_data_in` = 0 outside FEED.
- Words are forwarded unmodified; no arithmetic on data.

## Timing
- Reset values: `state` = IDLE, `owner` = 0, `last_grant` = 1 (requester 0 wins first tie), counters = 0; every output 0.
- Arbitration costs exactly one cycle: requests are sampled in IDLE; the first input handshake can occur in the following cycle.
- FEED/DRAIN forwarding is combinational (zero latency); valid/ready/data paths are pure muxes on registered `state`/`owner`.
- Requester valid dropping mid-vector in FEED: the arbiter waits in FEED; the grant is held and never preempted.
- Consumer backpressure in DRAIN (`m_ready` = 0): `e_m_ready` = 0, and the engine holds its word.
- A new request arriving in the last DRAIN cycle is seen in IDLE the next cycle; the minimum gap between vectors is 1 IDLE cycle.
- Reset mid-FEED/DRAIN: all state returns to reset values next edge; the engine is reset by the same signal, so the partial vector is discarded.

## Configuration
- `LAYER_ARB_PERF_EN` defined: adds outputs `done_cnt0`, `done_cnt1` (16 bits each). These are per-requester counts of completed vectors, incremented on the final DRAIN handshake, saturating at 65535, and cleared by `reset`.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then `s0_valid` held with words 1..8, `m0_ready` = 1 -> `s0_ready` first high 1 cycle after request; the 8 words appear on `e_data_in`; the 8 engine outputs appear on `m0_data` only; `m1_valid` stays 0; `busy` falls after the 8th output.
- Both `s0_valid`/`s1_valid` high from reset -> requester 0 served first, then requester 1 (`owner` = 1); repeat twice -> strict alternation 0,1,0,1.
- `s1_valid` asserted during requester 0's FEED -> `s1_ready` = 0 until requester 0's DRAIN completes, then requester 1 is granted.
- `m0_ready` low for 5 cycles mid-DRAIN -> `e_m_ready` = 0 for those cycles, no word lost or duplicated, `out_cnt` frozen.
- `reset` pulsed after 4 of 8 input words -> next cycle all outputs 0, `busy` = 0; a fresh 8-word vector then completes correctly.
- With `LAYER_ARB_PERF_EN`: 3 vectors on requester 0 and 2 on requester 1 -> `done_cnt0` = 3, `done_cnt1` = 2.
